// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, halt word, PC step, fetch FSM states
// and the IF/ID payload. The decode stage and hazard unit import the same package.
package fetch_unit_pkg;

  localparam int unsigned PC_WIDTH    = 64;
  localparam int unsigned INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] HALT_WORD = 32'h0000_0000;
  localparam logic [PC_WIDTH-1:0]    PC_STEP   = 64'd4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, pipeline controls and IF/ID outputs.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [PC_WIDTH-1:0]    ImemAddress;
  logic [INSTR_WIDTH-1:0] ImemData;
  logic                   Stall;
  logic                   Redirect;
  logic [PC_WIDTH-1:0]    RedirectTarget;
  logic [INSTR_WIDTH-1:0] Instr;
  logic [PC_WIDTH-1:0]    InstrPC;
  logic                   InstrValid;
  logic                   Halted;
  logic                   Fault;
  logic [31:0]            FetchCount;

  modport master (
    output ImemAddress, Instr, InstrPC, InstrValid, Halted, Fault, FetchCount,
    input  ImemData, Stall, Redirect, RedirectTarget
  );

  modport slave (
    input  ImemAddress, Instr, InstrPC, InstrValid, Halted, Fault, FetchCount,
    output ImemData, Stall, Redirect, RedirectTarget
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID holding register: flush clears valid only, load captures a new entry,
// otherwise the entry holds.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  if_id_t entry_in,
  output if_id_t entry,
  output logic   valid
);

  if_id_t entry_q, entry_d;
  logic   valid_q, valid_d;

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      entry_d = entry_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  assign entry = entry_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// PC register, next-PC selection and RUN/HALTED/FAULT control for the fetch stage;
// the instruction memory is combinational so the word is captured the cycle it is addressed.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 64'h0
) (
  input  logic          CLK,
  input  logic          Reset_L,
  fetch_unit_if.master  bus
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         fetch_count_q, fetch_count_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;
  logic                ifid_load, ifid_flush;
  if_id_t              ifid_in, ifid_out;
  logic                ifid_valid;

  assign ifid_in = '{pc: pc_q, instr: bus.ImemData};

  // Priority: fault absorbs, misaligned redirect, redirect, stall, then normal fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    halted_d      = halted_q;
    fault_d       = fault_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;

    if (state_q == FAULT) begin
      state_d = FAULT;
    end else if (bus.Redirect && (bus.RedirectTarget[1:0] != 2'b00)) begin
      state_d    = FAULT;
      fault_d    = 1'b1;
      ifid_flush = 1'b1;
    end else if (bus.Redirect) begin
      state_d    = RUN;
      pc_d       = bus.RedirectTarget;
      halted_d   = 1'b0;
      ifid_flush = 1'b1;
    end else if (bus.Stall) begin
      state_d = state_q;
    end else if (state_q == RUN) begin
      if (bus.ImemData == HALT_WORD) begin
        state_d    = HALTED;
        halted_d   = 1'b1;
        ifid_flush = 1'b1;
      end else begin
        pc_d          = pc_q + PC_STEP;
        fetch_count_d = fetch_count_q + 32'd1;
        ifid_load     = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      fetch_count_q <= 32'd0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (CLK),
    .rst_n    (Reset_L),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .entry_in (ifid_in),
    .entry    (ifid_out),
    .valid    (ifid_valid)
  );

  assign bus.ImemAddress = pc_q;
  assign bus.Instr       = ifid_out.instr;
  assign bus.InstrPC     = ifid_out.pc;
  assign bus.InstrValid  = ifid_valid;
  assign bus.Halted      = halted_q;
  assign bus.Fault       = fault_q;
  assign bus.FetchCount  = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch stage sitting directly upstream of the instruction memory. It drives the instruction-memory address, captures the returned 32-bit word into an IF/ID holding register for the decode stage, and handles stalls, branch redirects and end-of-program halt. The instruction memory is combinational, so the fetched word is sampled in the same cycle the address is driven.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `CLK`  in  1: rising-edge clock.
- `Reset_L`  in  1: asynchronous, active-low reset.
- `ImemAddress`  out  64: fetch address, equals current PC.
- `ImemData`  in  32: instruction word from instruction memory for `ImemAddress`.
- `Stall`  in  1: decode not ready; hold PC and IF/ID register.
- `Redirect`  in  1: taken branch/jump from a later stage.
- `RedirectTarget`  in  64: new PC when `Redirect`=1.
- `Instr`  out  32: IF/ID instruction.
- `InstrPC`  out  64: PC of `Instr`.
- `InstrValid`  out  1: `Instr`/`InstrPC` hold a real instruction.
- `Halted`  out  1: fetch stopped on a 32'h00000000 word.
- `Fault`  out  1: misaligned redirect target seen; sticky until reset.
- `FetchCount`  out  32: number of instructions delivered (valid IF/ID loads).

## Operation
- States: `RUN`, `HALTED`, `FAULT`. Reset enters `RUN`.
- `ImemAddress` = PC, combinational from PC register.
- Per rising edge, priority highest first:
  1. `Redirect`=1 and `RedirectTarget[1:0]`≠0: go `FAULT`, `Fault`<=1, `InstrValid`<=0, PC holds.
  2. `Redirect`=1 (aligned, any state except `FAULT`): PC<=`RedirectTarget`, `InstrValid`<=0 (flush), state<=`RUN`, `Halted`<=0. Overrides `Stall`.
  3. `Stall`=1: PC, `Instr`, `InstrPC`, `InstrValid`, `FetchCount` all hold.
  4. `RUN` and `ImemData`=32'h0: state<=`HALTED`, `Halted`<=1, `InstrValid`<=0, PC holds.
  5. `RUN` otherwise: `Instr`<=`ImemData`, `InstrPC`<=PC, `InstrValid`<=1, PC<=PC+4, `FetchCount`<=`FetchCount`+1.
- `HALTED`: PC holds, `InstrValid`=0; only an aligned `Redirect` leaves it (a zero word fetched on a wrong path is recovered by the later redirect).
- `FAULT`: absorbing until reset; all redirects ignored.
- PC+4 is 64-bit modulo 2^64 (wraps 64'hFFFF_FFFF_FFFF_FFFC -> 0). `FetchCount` wraps at 2^32.

## Timing
- Reset (async, `Reset_L`=0): PC=`RESET_PC`, `Instr`=0, `InstrPC`=0, `InstrValid`=0, `Halted`=0, `Fault`=0, `FetchCount`=0, state `RUN`. Takes effect immediately, including mid-redirect or mid-stall.
- First edge after reset release: IF/ID loads word at `RESET_PC`; `InstrValid`=1 from cycle 1.
- Fetch latency: one cycle, address in cycle n, `Instr` valid after edge n.
- Redirect penalty: one bubble. Redirect at edge n, `InstrValid`=0 after edge n, target instruction valid after edge n+1.
- `Stall` and `Redirect` are sampled only at the rising edge. No combinational path from `Stall`/`Redirect` to any output except through registers.

## Structure
- Shared package: `PC_WIDTH`=64, `INSTR_WIDTH`=32, `HALT_WORD`=32'h00000000, `PC_STEP`=4, fetch-state enum (`RUN`/`HALTED`/`FAULT`). The decode stage and hazard unit use these same definitions.
- One natural sub-module, `if_id_reg`: the IF/ID holding register with load/hold/flush controls. PC, next-PC select and FSM stay in `fetch_unit`.

## Test plan
- Reset then free run with program at 0x000: after edge 1, `Instr`=32'hF84003E9, `InstrPC`=0x000. After edge 2, `Instr`=32'hF84083EA, `InstrPC`=0x004. `FetchCount`=2.
- `Stall`=1 for 3 cycles with `InstrPC`=0x008: `Instr`=32'hF84103EB, PC=0x00C and `FetchCount` unchanged. On release, the next edge loads 0x00C/32'hF84183EC.
- Redirect to 0x020 at edge where PC=0x02C: `InstrValid`=0 for one cycle, then `Instr`=32'h8B0901AD, `InstrPC`=0x020. Repeat with `Stall`=1 asserted simultaneously and get the same result.
- Fetch reaches 0x058 (word 0): `Halted`=1, `InstrValid`=0, PC stays 0x058 for 10 cycles. Then redirect to 0x034 clears `Halted`, and `Instr`=32'hD2E24689 follows.
- Redirect to 0x022: `Fault`=1, PC holds, a later redirect to 0x000 is ignored. Asserting `Reset_L`=0 asynchronously clears `Fault`, and the PC returns to 0x000.
- Async reset pulse mid-cycle while `InstrValid`=1: all outputs go to reset values before the next edge.
